// File: rtl/irq_pkg.sv
// irq_pkg: shared types and defaults for the interrupt controller.
//   irq_state_t        - controller FSM states
//   VEC_BASE_DEFAULT   - default handler address of source 0
//   VEC_STRIDE_DEFAULT - default byte spacing between handler entry points
//   SYNC_STAGES_MIN    - shallowest synchroniser allowed
//   id_width()         - width of a source index (at least one bit)
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_t;

  localparam logic [31:0] VEC_BASE_DEFAULT   = 32'h0000_0100;
  localparam int unsigned VEC_STRIDE_DEFAULT = 4;
  localparam int unsigned SYNC_STAGES_MIN    = 2;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// irq_sync: one interrupt source's input conditioning.
//   clk         - core clock
//   rst         - synchronous active-low reset
//   src_i       - asynchronous interrupt line, active high
//   edge_mode_i - 1: rising-edge latched, 0: level
//   clr_i       - acknowledge of this source (ignored in level mode)
//   pend_o      - registered pending bit
module irq_sync
  import irq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_MIN
) (
  input  logic clk,
  input  logic rst,
  input  logic src_i,
  input  logic edge_mode_i,
  input  logic clr_i,
  output logic pend_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_s;
  logic                   s_q;
  logic                   rise;
  logic                   pend_q;
  logic                   pend_d;

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign sync_d = {sync_q[SYNC_STAGES-2:0], src_i};
  assign rise   = sync_s & ~s_q;

  // In edge mode a rise in the same cycle as the clear wins so that edge is
  // not lost. In level mode the bit loads the same value as s_q, so it mirrors
  // the registered synchronised level.
  always_comb begin
    pend_d = pend_q;
    if (edge_mode_i) begin
      pend_d = rise | (pend_q & ~clr_i);
    end else begin
      pend_d = sync_s;
    end
  end

  // Everything clears on reset, so a line already high at release looks like
  // a rising edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      s_q    <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_q    <= sync_s;
      pend_q <= pend_d;
    end
  end

  assign pend_o = pend_q;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: multi-source vectored interrupt controller.
//   clk, rst       - core clock, synchronous active-low reset
//   irq_src        - asynchronous interrupt lines
//   edge_mode      - per source: 1 edge-latched, 0 level
//   irq_mask       - per source: 1 masked (pending still latches)
//   irq_en         - global enable, gates only the IDLE->REQ step
//   irq_req        - request to flush and redirect
//   irq_id         - source being requested or serviced
//   irq_vec_addr   - handler address for irq_id
//   irq_ack        - pipeline accepted the request; ack_pc is the return PC
//   irq_ret        - handler returned
//   in_service     - handler active
//   epc            - captured return PC
//   pending        - pending vector
module irq_ctrl
  import irq_pkg::*;
#(
  parameter int unsigned          NUM_SRC     = 4,
  parameter int unsigned          ADDR_W      = 32,
  parameter logic [ADDR_W-1:0]    VEC_BASE    = ADDR_W'(VEC_BASE_DEFAULT),
  parameter int unsigned          VEC_STRIDE  = VEC_STRIDE_DEFAULT,
  parameter int unsigned          SYNC_STAGES = SYNC_STAGES_MIN,
  localparam int unsigned         ID_W        = id_width(NUM_SRC)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_SRC-1:0]  irq_src,
  input  logic [NUM_SRC-1:0]  edge_mode,
  input  logic [NUM_SRC-1:0]  irq_mask,
  input  logic                irq_en,
  output logic                irq_req,
  output logic [ID_W-1:0]     irq_id,
  output logic [ADDR_W-1:0]   irq_vec_addr,
  input  logic                irq_ack,
  input  logic [ADDR_W-1:0]   ack_pc,
  input  logic                irq_ret,
  output logic                in_service,
  output logic [ADDR_W-1:0]   epc,
  output logic [NUM_SRC-1:0]  pending
);

  irq_state_t          state_q;
  logic                req_q;
  logic                svc_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   vec_q;
  logic [ADDR_W-1:0]   epc_q;

  logic [NUM_SRC-1:0]  pend;
  logic [NUM_SRC-1:0]  elig;
  logic [NUM_SRC-1:0]  clr;
  logic [ID_W-1:0]     win;
  logic                any_elig;

  function automatic logic [ADDR_W-1:0] vec_addr(input logic [ID_W-1:0] id);
    return VEC_BASE + ADDR_W'(id) * ADDR_W'(VEC_STRIDE);
  endfunction

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    // Only the source actually being acknowledged is cleared.
    assign clr[i] = (state_q == IRQ_REQ) && irq_ack && (id_q == ID_W'(i));

    irq_sync #(
      .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
      .clk         (clk),
      .rst         (rst),
      .src_i       (irq_src[i]),
      .edge_mode_i (edge_mode[i]),
      .clr_i       (clr[i]),
      .pend_o      (pend[i])
    );
  end

  assign elig     = pend & ~irq_mask;
  assign any_elig = |elig;

  // Fixed priority: lowest index wins, so scan from the top down.
  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (elig[i]) begin
        win = ID_W'(i);
      end
    end
  end

  // Once in REQ the request is held until acknowledged; mask and enable are
  // no longer consulted. id/vector/epc hold through IDLE until replaced.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IRQ_IDLE;
      req_q   <= 1'b0;
      svc_q   <= 1'b0;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
      epc_q   <= '0;
    end else begin
      case (state_q)
        IRQ_IDLE: begin
          if (irq_en && any_elig) begin
            state_q <= IRQ_REQ;
            req_q   <= 1'b1;
            id_q    <= win;
            vec_q   <= vec_addr(win);
          end
        end
        IRQ_REQ: begin
          if (irq_ack) begin
            state_q <= IRQ_SERVICE;
            req_q   <= 1'b0;
            svc_q   <= 1'b1;
            epc_q   <= ack_pc;
          end
        end
        IRQ_SERVICE: begin
          if (irq_ret) begin
            state_q <= IRQ_IDLE;
            svc_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IRQ_IDLE;
          req_q   <= 1'b0;
          svc_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_req      = req_q;
  assign in_service   = svc_q;
  assign irq_id       = id_q;
  assign irq_vec_addr = vec_q;
  assign epc          = epc_q;
  assign pending      = pend;

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: cycle-vector bench for irq_ctrl with default parameters.
// Each record holds the inputs applied before an edge and the outputs
// expected just after it; the driver queues the record and a monitor pops
// and compares it one time unit after the edge.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  irq_src;
  logic [3:0]  edge_mode;
  logic [3:0]  irq_mask;
  logic        irq_en;
  logic        irq_req;
  logic [1:0]  irq_id;
  logic [31:0] irq_vec_addr;
  logic        irq_ack;
  logic [31:0] ack_pc;
  logic        irq_ret;
  logic        in_service;
  logic [31:0] epc;
  logic [3:0]  pending;

  always #5 clk = ~clk;

  irq_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .irq_src      (irq_src),
    .edge_mode    (edge_mode),
    .irq_mask     (irq_mask),
    .irq_en       (irq_en),
    .irq_req      (irq_req),
    .irq_id       (irq_id),
    .irq_vec_addr (irq_vec_addr),
    .irq_ack      (irq_ack),
    .ack_pc       (ack_pc),
    .irq_ret      (irq_ret),
    .in_service   (in_service),
    .epc          (epc),
    .pending      (pending)
  );

  typedef struct {
    logic        r;
    logic [3:0]  s;
    logic [3:0]  e;
    logic [3:0]  m;
    logic        en;
    logic        ak;
    logic [31:0] pc;
    logic        rt;
    logic        q;
    logic [1:0]  id;
    logic        sv;
    logic [31:0] ep;
    logic [3:0]  pd;
    int          tag;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ntag   = 0;

  localparam logic [3:0] F = 4'hF;
  localparam logic [3:0] D = 4'hD;

  function automatic vec_t mk(input logic r, input logic [3:0] s, input logic [3:0] e,
                              input logic [3:0] m, input logic en, input logic ak,
                              input logic [31:0] pc, input logic rt, input logic q,
                              input logic [1:0] id, input logic sv, input logic [31:0] ep,
                              input logic [3:0] pd);
    vec_t v;
    v.r = r;  v.s = s;   v.e = e;  v.m = m;   v.en = en; v.ak = ak; v.pc = pc;
    v.rt = rt; v.q = q;  v.id = id; v.sv = sv; v.ep = ep; v.pd = pd; v.tag = 0;
    return v;
  endfunction

  task automatic chk(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL c%0d.%s actual=%0h required=%0h", tag, nm, act, req);
    end
  endtask

  task automatic drive(input vec_t v);
    v.tag     = ntag;
    ntag++;
    rst       = v.r;
    irq_src   = v.s;
    edge_mode = v.e;
    irq_mask  = v.m;
    irq_en    = v.en;
    irq_ack   = v.ak;
    ack_pc    = v.pc;
    irq_ret   = v.rt;
    exp_q.push_back(v);
    @(posedge clk);
    #2;
  endtask

  always begin
    vec_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("req",  e.tag, 32'(irq_req),    32'(e.q));
      chk("id",   e.tag, 32'(irq_id),     32'(e.id));
      chk("vec",  e.tag, irq_vec_addr,    32'h100 + 32'(e.id) * 32'd4);
      chk("svc",  e.tag, 32'(in_service), 32'(e.sv));
      chk("epc",  e.tag, epc,             e.ep);
      chk("pend", e.tag, 32'(pending),    32'(e.pd));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // ---- reset, then edge on src2 -> request, ack, return
    //                r  src edge msk en ak pc        rt |req id svc epc      pend
    tbl.push_back(mk(0, 0,   F,  0, 1, 0, 0,       0,  0, 0, 0, 0,       0));
    tbl.push_back(mk(0, 0,   F,  0, 1, 0, 0,       0,  0, 0, 0, 0,       0));
    tbl.push_back(mk(1, 4,   F,  0, 1, 0, 0,       0,  0, 0, 0, 0,       0));
    tbl.push_back(mk(1, 4,   F,  0, 1, 0, 0,       0,  0, 0, 0, 0,       0));
    tbl.push_back(mk(1, 4,   F,  0, 1, 0, 0,       0,  0, 0, 0, 0,       4));
    tbl.push_back(mk(1, 4,   F,  0, 1, 0, 0,       0,  1, 2, 0, 0,       4));
    tbl.push_back(mk(1, 4,   F,  0, 1, 1, 'h40,    0,  0, 2, 1, 'h40,    0));
    tbl.push_back(mk(1, 0,   F,  0, 1, 0, 0,       0,  0, 2, 1, 'h40,    0));
    tbl.push_back(mk(1, 0,   F,  0, 1, 0, 0,       1,  0, 2, 0, 'h40,    0));
    tbl.push_back(mk(1, 0,   F,  0, 1, 0, 0,       0,  0, 2, 0, 'h40,    0));
    // ---- simultaneous edges on src1 and src3
    tbl.push_back(mk(1, 'hA, F,  0, 1, 0, 0,       0,  0, 2, 0, 'h40,    0));
    tbl.push_back(mk(1, 'hA, F,  0, 1, 0, 0,       0,  0, 2, 0, 'h40,    0));
    tbl.push_back(mk(1, 'hA, F,  0, 1, 0, 0,       0,  0, 2, 0, 'h40,    'hA));
    tbl.push_back(mk(1, 0,   F,  0, 1, 0, 0,       0,  1, 1, 0, 'h40,    'hA));
    tbl.push_back(mk(1, 0,   F,  0, 1, 1, 'h80,    0,  0, 1, 1, 'h80,    8));
    tbl.push_back(mk(1, 0,   F,  0, 1, 0, 0,       1,  0, 1, 0, 'h80,    8));
    tbl.push_back(mk(1, 0,   F,  0, 1, 0, 0,       0,  1, 3, 0, 'h80,    8));
    tbl.push_back(mk(1, 0,   F,  0, 1, 1, 'h84,    0,  0, 3, 1, 'h84,    0));
    tbl.push_back(mk(1, 0,   F,  0, 1, 0, 0,       1,  0, 3, 0, 'h84,    0));
    // ---- masked src0 with a two-cycle pulse, then unmask
    tbl.push_back(mk(1, 1,   F,  1, 1, 0, 0,       0,  0, 3, 0, 'h84,    0));
    tbl.push_back(mk(1, 1,   F,  1, 1, 0, 0,       0,  0, 3, 0, 'h84,    0));
    tbl.push_back(mk(1, 0,   F,  1, 1, 0, 0,       0,  0, 3, 0, 'h84,    1));
    tbl.push_back(mk(1, 0,   F,  1, 1, 0, 0,       0,  0, 3, 0, 'h84,    1));
    tbl.push_back(mk(1, 0,   F,  0, 1, 0, 0,       0,  1, 0, 0, 'h84,    1));
    tbl.push_back(mk(1, 0,   F,  1, 1, 0, 0,       0,  1, 0, 0, 'h84,    1));
    tbl.push_back(mk(1, 0,   F,  0, 1, 1, 'h10,    0,  0, 0, 1, 'h10,    0));
    tbl.push_back(mk(1, 0,   F,  0, 1, 0, 0,       1,  0, 0, 0, 'h10,    0));
    // ---- level src1 held through return; src2 edge during service
    tbl.push_back(mk(1, 2,   D,  0, 1, 0, 0,       0,  0, 0, 0, 'h10,    0));
    tbl.push_back(mk(1, 2,   D,  0, 1, 0, 0,       0,  0, 0, 0, 'h10,    0));
    tbl.push_back(mk(1, 2,   D,  0, 1, 0, 0,       0,  0, 0, 0, 'h10,    2));
    tbl.push_back(mk(1, 2,   D,  0, 1, 0, 0,       0,  1, 1, 0, 'h10,    2));
    tbl.push_back(mk(1, 2,   D,  0, 1, 1, 'h200,   0,  0, 1, 1, 'h200,   2));
    tbl.push_back(mk(1, 6,   D,  0, 1, 0, 0,       0,  0, 1, 1, 'h200,   2));
    tbl.push_back(mk(1, 6,   D,  0, 1, 0, 0,       0,  0, 1, 1, 'h200,   2));
    tbl.push_back(mk(1, 6,   D,  0, 1, 0, 0,       0,  0, 1, 1, 'h200,   6));
    tbl.push_back(mk(1, 6,   D,  0, 1, 0, 0,       1,  0, 1, 0, 'h200,   6));
    tbl.push_back(mk(1, 6,   D,  0, 1, 0, 0,       0,  1, 1, 0, 'h200,   6));
    tbl.push_back(mk(1, 4,   D,  0, 1, 1, 'h204,   0,  0, 1, 1, 'h204,   6));
    tbl.push_back(mk(1, 4,   D,  0, 1, 0, 0,       0,  0, 1, 1, 'h204,   6));
    tbl.push_back(mk(1, 0,   D,  0, 1, 0, 0,       1,  0, 1, 0, 'h204,   4));
    tbl.push_back(mk(1, 0,   D,  0, 1, 0, 0,       0,  1, 2, 0, 'h204,   4));
    tbl.push_back(mk(1, 4,   D,  0, 1, 0, 0,       0,  1, 2, 0, 'h204,   4));
    tbl.push_back(mk(1, 4,   D,  0, 1, 0, 0,       0,  1, 2, 0, 'h204,   4));
    // ack lands on the same edge as a new src2 rise: pending stays set
    tbl.push_back(mk(1, 4,   D,  0, 1, 1, 'h300,   0,  0, 2, 1, 'h300,   4));
    tbl.push_back(mk(1, 4,   D,  0, 1, 0, 0,       1,  0, 2, 0, 'h300,   4));
    tbl.push_back(mk(1, 0,   D,  0, 1, 0, 0,       0,  1, 2, 0, 'h300,   4));
    tbl.push_back(mk(1, 0,   D,  0, 1, 1, 'h304,   0,  0, 2, 1, 'h304,   0));
    tbl.push_back(mk(1, 0,   D,  0, 1, 0, 0,       1,  0, 2, 0, 'h304,   0));
    // ---- irq_en low with pending; stray ack in IDLE, stray ret in REQ
    tbl.push_back(mk(1, 8,   D,  0, 0, 0, 0,       0,  0, 2, 0, 'h304,   0));
    tbl.push_back(mk(1, 8,   D,  0, 0, 0, 0,       0,  0, 2, 0, 'h304,   0));
    tbl.push_back(mk(1, 0,   D,  0, 0, 0, 0,       0,  0, 2, 0, 'h304,   8));
    tbl.push_back(mk(1, 0,   D,  0, 0, 0, 0,       0,  0, 2, 0, 'h304,   8));
    tbl.push_back(mk(1, 0,   D,  0, 0, 1, 'h999,   0,  0, 2, 0, 'h304,   8));
    tbl.push_back(mk(1, 0,   D,  0, 0, 0, 0,       1,  0, 2, 0, 'h304,   8));
    tbl.push_back(mk(1, 0,   D,  0, 1, 0, 0,       0,  1, 3, 0, 'h304,   8));
    tbl.push_back(mk(1, 0,   D,  0, 1, 0, 0,       1,  1, 3, 0, 'h304,   8));
    tbl.push_back(mk(1, 0,   D,  0, 1, 1, 'h500,   0,  0, 3, 1, 'h500,   0));

    foreach (tbl[i]) drive(tbl[i]);

    // ---- reset while in SERVICE
    drive(mk(0, 0, D, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    // ---- build a request on src0, then reset while in REQ with src0 high
    drive(mk(1, 1, D, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    drive(mk(1, 1, D, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    drive(mk(1, 1, D, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1));
    drive(mk(1, 1, D, 0, 1, 0, 0, 0,  1, 0, 0, 0, 1));
    drive(mk(0, 1, D, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    // ---- line still high at release counts as a fresh rising edge
    drive(mk(1, 1, D, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    drive(mk(1, 1, D, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0));
    drive(mk(1, 1, D, 0, 1, 0, 0, 0,  0, 0, 0, 0, 1));
    drive(mk(1, 1, D, 0, 1, 0, 0, 0,  1, 0, 0, 0, 1));

    for (int n = 0; n < 5 && exp_q.size() > 0; n++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
